// File: rtl/alsu_pipe_pkg.sv
// Shared types for the pipelined ALSU: opcode encoding, stage-1 control
// payload and the illegal-operation decode.
package alsu_pipe_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND    = 3'b000,
    OP_XOR    = 3'b001,
    OP_ADD    = 3'b010,
    OP_MUL    = 3'b011,
    OP_SHIFT  = 3'b100,
    OP_ROTATE = 3'b101,
    OP_INV6   = 3'b110,
    OP_INV7   = 3'b111
  } opcode_e;

  // Control fields captured alongside the operands in stage 1
  typedef struct packed {
    opcode_e op;
    logic    cin;
    logic    serial_in;
    logic    direction;
    logic    red_a;
    logic    red_b;
    logic    byp_a;
    logic    byp_b;
  } ctrl_t;

  // Reserved opcodes, or a reduction request on anything other than AND/XOR
  function automatic logic is_illegal(input opcode_e op, input logic red_a, input logic red_b);
    logic illegal;
    illegal = (op == OP_INV6) || (op == OP_INV7);
    if ((red_a || red_b) && (op != OP_AND) && (op != OP_XOR)) begin
      illegal = 1'b1;
    end
    return illegal;
  endfunction

endpackage

// File: rtl/alsu_pipe_calc.sv
// Combinational stage-2 datapath of the pipelined ALSU.
// Turns the stage-1 operands/controls and the current result register into
// the next result value, and flags illegal operations.
// Configuration macro: ALSU_FULL_ADDER_EN (when defined, ADD includes cin).
// Ports:
//   a_i, b_i       signed WIDTH-bit operands from stage 1
//   ctrl_i         stage-1 control payload
//   out_i          current result register (source for SHIFT/ROTATE)
//   next_out_c_o   next result value
//   illegal_c_o    operation is illegal
module alsu_pipe_calc
  import alsu_pipe_pkg::*;
#(
  parameter int unsigned WIDTH  = 3,
  parameter bit          PRIO_B = 1'b0,
  localparam int unsigned OUT_W = 2 * WIDTH
) (
  input  logic signed [WIDTH-1:0] a_i,
  input  logic signed [WIDTH-1:0] b_i,
  input  ctrl_t                   ctrl_i,
  input  logic [OUT_W-1:0]        out_i,
  output logic [OUT_W-1:0]        next_out_c_o,
  output logic                    illegal_c_o
);

  logic signed [OUT_W-1:0] a_ext;
  logic signed [OUT_W-1:0] b_ext;
  logic signed [OUT_W-1:0] cin_ext;
  logic [WIDTH-1:0]        and_ab;
  logic [WIDTH-1:0]        xor_ab;
  logic                    byp_use_b;
  logic                    red_use_b;
  logic                    red_and;
  logic                    red_xor;

  assign a_ext  = {{(OUT_W-WIDTH){a_i[WIDTH-1]}}, a_i};
  assign b_ext  = {{(OUT_W-WIDTH){b_i[WIDTH-1]}}, b_i};
  assign and_ab = a_i & b_i;
  assign xor_ab = a_i ^ b_i;

  // B is chosen when it is the only one requested, or both are and B has priority
  assign byp_use_b = ctrl_i.byp_b && (!ctrl_i.byp_a || PRIO_B);
  assign red_use_b = ctrl_i.red_b && (!ctrl_i.red_a || PRIO_B);
  assign red_and   = red_use_b ? (&b_i) : (&a_i);
  assign red_xor   = red_use_b ? (^b_i) : (^a_i);

`ifdef ALSU_FULL_ADDER_EN
  assign cin_ext = {{(OUT_W-1){1'b0}}, ctrl_i.cin};
`else
  logic unused_cin;
  assign cin_ext    = '0;
  assign unused_cin = ctrl_i.cin;
`endif

  // Priority: illegal > bypass > opcode
  always_comb begin
    next_out_c_o = '0;
    illegal_c_o  = is_illegal(ctrl_i.op, ctrl_i.red_a, ctrl_i.red_b);
    if (illegal_c_o) begin
      next_out_c_o = '0;
    end else if (ctrl_i.byp_a || ctrl_i.byp_b) begin
      next_out_c_o = byp_use_b ? b_ext : a_ext;
    end else begin
      unique case (ctrl_i.op)
        OP_AND: begin
          if (ctrl_i.red_a || ctrl_i.red_b) next_out_c_o = {{(OUT_W-1){1'b0}}, red_and};
          else                              next_out_c_o = {{(OUT_W-WIDTH){and_ab[WIDTH-1]}}, and_ab};
        end
        OP_XOR: begin
          if (ctrl_i.red_a || ctrl_i.red_b) next_out_c_o = {{(OUT_W-1){1'b0}}, red_xor};
          else                              next_out_c_o = {{(OUT_W-WIDTH){xor_ab[WIDTH-1]}}, xor_ab};
        end
        OP_ADD:    next_out_c_o = a_ext + b_ext + cin_ext;
        OP_MUL:    next_out_c_o = a_ext * b_ext;
        OP_SHIFT: begin
          if (ctrl_i.direction) next_out_c_o = {out_i[OUT_W-2:0], ctrl_i.serial_in};
          else                  next_out_c_o = {ctrl_i.serial_in, out_i[OUT_W-1:1]};
        end
        OP_ROTATE: begin
          if (ctrl_i.direction) next_out_c_o = {out_i[OUT_W-2:0], out_i[OUT_W-1]};
          else                  next_out_c_o = {out_i[0], out_i[OUT_W-1:1]};
        end
        OP_INV6, OP_INV7: next_out_c_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/alsu_pipe.sv
// Pipelined arithmetic/logic/shift unit. Stage 1 captures operands and
// controls, stage 2 updates the result, LED blink pattern and the saturating
// illegal-op counter. Bubbles propagate and leave all outputs holding.
// Configuration macro: ALSU_FULL_ADDER_EN (when defined, ADD includes cin).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid            operands/controls valid this cycle
//   A, B                signed WIDTH-bit operands
//   opcode              operation (opcode_e encoding)
//   cin                 carry in for ADD
//   serial_in           bit inserted by SHIFT
//   direction           1 = left, 0 = right
//   red_op_A, red_op_B  reduction request on A/B
//   bypass_A, bypass_B  pass operand straight through
//   out_valid           out updated this cycle
//   out                 2*WIDTH-bit result register
//   leds                toggles on each illegal op, cleared by legal ones
//   err_cnt             saturating count of illegal ops
module alsu_pipe
  import alsu_pipe_pkg::*;
#(
  parameter int unsigned WIDTH          = 3,
  parameter int unsigned LED_W          = 16,
  parameter int unsigned CNT_W          = 8,
  parameter string       INPUT_PRIORITY = "A",
  localparam int unsigned OUT_W         = 2 * WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] A,
  input  logic signed [WIDTH-1:0] B,
  input  logic [OP_W-1:0]         opcode,
  input  logic                    cin,
  input  logic                    serial_in,
  input  logic                    direction,
  input  logic                    red_op_A,
  input  logic                    red_op_B,
  input  logic                    bypass_A,
  input  logic                    bypass_B,
  output logic                    out_valid,
  output logic [OUT_W-1:0]        out,
  output logic [LED_W-1:0]        leds,
  output logic [CNT_W-1:0]        err_cnt
);

  localparam bit PRIO_B = (INPUT_PRIORITY == "B");

  logic                    s1_valid_q, s1_valid_d;
  logic signed [WIDTH-1:0] a_q, a_d;
  logic signed [WIDTH-1:0] b_q, b_d;
  ctrl_t                   ctrl_q, ctrl_d;
  logic                    out_valid_q, out_valid_d;
  logic [OUT_W-1:0]        out_q, out_d;
  logic [LED_W-1:0]        leds_q, leds_d;
  logic [CNT_W-1:0]        err_cnt_q, err_cnt_d;

  logic [OUT_W-1:0]        next_out;
  logic                    illegal;

  alsu_pipe_calc #(
    .WIDTH  (WIDTH),
    .PRIO_B (PRIO_B)
  ) u_calc (
    .a_i          (a_q),
    .b_i          (b_q),
    .ctrl_i       (ctrl_q),
    .out_i        (out_q),
    .next_out_c_o (next_out),
    .illegal_c_o  (illegal)
  );

  // Stage 1: capture operands and controls on valid input
  always_comb begin
    s1_valid_d = in_valid;
    a_d        = a_q;
    b_d        = b_q;
    ctrl_d     = ctrl_q;
    if (in_valid) begin
      a_d              = A;
      b_d              = B;
      ctrl_d.op        = opcode_e'(opcode);
      ctrl_d.cin       = cin;
      ctrl_d.serial_in = serial_in;
      ctrl_d.direction = direction;
      ctrl_d.red_a     = red_op_A;
      ctrl_d.red_b     = red_op_B;
      ctrl_d.byp_a     = bypass_A;
      ctrl_d.byp_b     = bypass_B;
    end
  end

  // Stage 2: result, LED pattern and error counter; hold on bubbles
  always_comb begin
    out_valid_d = s1_valid_q;
    out_d       = out_q;
    leds_d      = leds_q;
    err_cnt_d   = err_cnt_q;
    if (s1_valid_q) begin
      out_d = next_out;
      if (illegal) begin
        leds_d = ~leds_q;
        if (err_cnt_q != {CNT_W{1'b1}}) err_cnt_d = err_cnt_q + CNT_W'(1);
      end else begin
        leds_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      ctrl_q      <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      leds_q      <= '0;
      err_cnt_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      ctrl_q      <= ctrl_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      leds_q      <= leds_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign leds      = leds_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_alsu_pipe.sv
// Directed bench for alsu_pipe (WIDTH=3). A second instance with CNT_W=2 and
// B operand priority shares the same inputs.
module tb_alsu_pipe;
  import alsu_pipe_pkg::*;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic signed [2:0] A, B;
  logic [2:0]        opcode;
  logic              cin, serial_in, direction;
  logic              red_op_A, red_op_B, bypass_A, bypass_B;

  logic        out_valid, out_valid_b;
  logic [5:0]  out, out_b;
  logic [15:0] leds, leds_b;
  logic [7:0]  err_cnt;
  logic [1:0]  err_cnt_b;

  int applied;
  int miscompares;

`ifdef ALSU_FULL_ADDER_EN
  localparam logic [5:0] EXP_ADD_CIN = 6'd7;
`else
  localparam logic [5:0] EXP_ADD_CIN = 6'd6;
`endif

  alsu_pipe #(.WIDTH(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B), .opcode(opcode),
    .cin(cin), .serial_in(serial_in), .direction(direction),
    .red_op_A(red_op_A), .red_op_B(red_op_B), .bypass_A(bypass_A), .bypass_B(bypass_B),
    .out_valid(out_valid), .out(out), .leds(leds), .err_cnt(err_cnt)
  );

  alsu_pipe #(.WIDTH(3), .CNT_W(2), .INPUT_PRIORITY("B")) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B), .opcode(opcode),
    .cin(cin), .serial_in(serial_in), .direction(direction),
    .red_op_A(red_op_A), .red_op_B(red_op_B), .bypass_A(bypass_A), .bypass_B(bypass_B),
    .out_valid(out_valid_b), .out(out_b), .leds(leds_b), .err_cnt(err_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b);
    in_valid  = 1'b1;
    opcode    = op;
    A         = a;
    B         = b;
    cin       = 1'b0;
    serial_in = 1'b0;
    direction = 1'b0;
    red_op_A  = 1'b0;
    red_op_B  = 1'b0;
    bypass_A  = 1'b0;
    bypass_B  = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(3'($urandom_range(0, 7)), 3'($urandom), 3'($urandom));
      tick();
      applied++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid[%0d]: got %b want 0", i, out_valid); end
      applied++; if (out !== 6'd0) begin miscompares++; $display("FAIL rst_out[%0d]: got %b want 000000", i, out); end
      applied++; if (leds !== 16'h0000) begin miscompares++; $display("FAIL rst_leds[%0d]: got %h want 0000", i, leds); end
      applied++; if (err_cnt !== 8'd0) begin miscompares++; $display("FAIL rst_err[%0d]: got %0d want 0", i, err_cnt); end
    end
    rst = 1'b0;
    drive(OP_ADD, 3'd1, 3'd2);
    tick();
    idle();
    applied++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_flush_valid: got %b want 0", out_valid); end
    tick();
    applied++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL rst_first_valid: got %b want 1", out_valid); end
    applied++; if (out !== 6'b000011) begin miscompares++; $display("FAIL rst_first_out: got %b want 000011", out); end
  endtask

  task automatic test_mul();
    drive(OP_MUL, 3'b100, 3'b011);
    tick();
    idle();
    applied++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mul_lat1_valid: got %b want 0", out_valid); end
    tick();
    applied++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL mul_valid: got %b want 1", out_valid); end
    applied++; if (out !== 6'b110100) begin miscompares++; $display("FAIL mul_out: got %b want 110100", out); end
    tick();
    applied++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bubble_valid: got %b want 0", out_valid); end
    applied++; if (out !== 6'b110100) begin miscompares++; $display("FAIL bubble_hold: got %b want 110100", out); end
  endtask

  task automatic test_add();
    drive(OP_ADD, 3'd3, 3'd3);
    cin = 1'b1;
    tick();
    drive(OP_ADD, 3'b100, 3'b100);
    tick();
    applied++; if (out !== EXP_ADD_CIN) begin miscompares++; $display("FAIL add_cin: got %b want %b", out, EXP_ADD_CIN); end
    idle();
    tick();
    applied++; if (out !== 6'b111000) begin miscompares++; $display("FAIL add_neg: got %b want 111000", out); end
  endtask

  task automatic test_shift_rotate();
    drive(OP_ADD, 3'd1, 3'd2);
    tick();
    drive(OP_ROTATE, 3'd0, 3'd0);
    tick();
    applied++; if (out !== 6'b000011) begin miscompares++; $display("FAIL sr_seed: got %b want 000011", out); end
    drive(OP_SHIFT, 3'd0, 3'd0);
    direction = 1'b1;
    tick();
    applied++; if (out !== 6'b100001) begin miscompares++; $display("FAIL rot_r1: got %b want 100001", out); end
    drive(OP_ROTATE, 3'd0, 3'd0);
    tick();
    applied++; if (out !== 6'b000010) begin miscompares++; $display("FAIL shl_0: got %b want 000010", out); end
    drive(OP_SHIFT, 3'd0, 3'd0);
    serial_in = 1'b1;
    tick();
    applied++; if (out !== 6'b000001) begin miscompares++; $display("FAIL rot_r2: got %b want 000001", out); end
    idle();
    tick();
    applied++; if (out !== 6'b100000) begin miscompares++; $display("FAIL shr_1: got %b want 100000", out); end
  endtask

  task automatic test_illegal();
    drive(OP_INV7, 3'd1, 3'd1);
    tick();
    drive(OP_INV7, 3'd2, 3'd2);
    tick();
    applied++; if (out !== 6'd0) begin miscompares++; $display("FAIL ill1_out: got %b want 000000", out); end
    applied++; if (leds !== 16'hFFFF) begin miscompares++; $display("FAIL ill1_leds: got %h want FFFF", leds); end
    applied++; if (err_cnt !== 8'd1) begin miscompares++; $display("FAIL ill1_err: got %0d want 1", err_cnt); end
    drive(OP_INV7, 3'd3, 3'd3);
    tick();
    applied++; if (leds !== 16'h0000) begin miscompares++; $display("FAIL ill2_leds: got %h want 0000", leds); end
    applied++; if (err_cnt !== 8'd2) begin miscompares++; $display("FAIL ill2_err: got %0d want 2", err_cnt); end
    idle();
    tick();
    applied++; if (leds !== 16'hFFFF) begin miscompares++; $display("FAIL ill3_leds: got %h want FFFF", leds); end
    applied++; if (err_cnt !== 8'd3) begin miscompares++; $display("FAIL ill3_err: got %0d want 3", err_cnt); end
    applied++; if (err_cnt_b !== 2'd3) begin miscompares++; $display("FAIL ill3_err_b: got %0d want 3", err_cnt_b); end
    tick();
    applied++; if (leds !== 16'hFFFF) begin miscompares++; $display("FAIL ill_hold_leds: got %h want FFFF", leds); end
    drive(OP_AND, 3'b101, 3'b011);
    tick();
    idle();
    tick();
    applied++; if (leds !== 16'h0000) begin miscompares++; $display("FAIL legal_leds: got %h want 0000", leds); end
    applied++; if (out !== 6'b000001) begin miscompares++; $display("FAIL and_out: got %b want 000001", out); end
    applied++; if (err_cnt !== 8'd3) begin miscompares++; $display("FAIL legal_err_hold: got %0d want 3", err_cnt); end
    drive(OP_INV6, 3'd0, 3'd0);
    tick();
    idle();
    tick();
    applied++; if (leds_b !== 16'hFFFF) begin miscompares++; $display("FAIL ill4_leds_b: got %h want FFFF", leds_b); end
    applied++; if (err_cnt !== 8'd4) begin miscompares++; $display("FAIL ill4_err: got %0d want 4", err_cnt); end
    applied++; if (err_cnt_b !== 2'd3) begin miscompares++; $display("FAIL err_sat_b: got %0d want 3", err_cnt_b); end
  endtask

  task automatic test_reduction();
    drive(OP_ADD, 3'd1, 3'd1);
    red_op_A = 1'b1;
    tick();
    drive(OP_AND, 3'b111, 3'b011);
    red_op_A = 1'b1;
    red_op_B = 1'b1;
    tick();
    applied++; if (out !== 6'd0) begin miscompares++; $display("FAIL red_add_out: got %b want 000000", out); end
    applied++; if (err_cnt !== 8'd5) begin miscompares++; $display("FAIL red_add_err: got %0d want 5", err_cnt); end
    applied++; if (leds !== 16'h0000) begin miscompares++; $display("FAIL red_add_leds: got %h want 0000", leds); end
    drive(OP_XOR, 3'b110, 3'b100);
    red_op_A = 1'b1;
    red_op_B = 1'b1;
    tick();
    applied++; if (out !== 6'd1) begin miscompares++; $display("FAIL red_and_prio_a: got %b want 000001", out); end
    applied++; if (out_b !== 6'd0) begin miscompares++; $display("FAIL red_and_prio_b: got %b want 000000", out_b); end
    drive(OP_XOR, 3'b111, 3'b010);
    red_op_B = 1'b1;
    tick();
    applied++; if (out !== 6'd0) begin miscompares++; $display("FAIL red_xor_prio_a: got %b want 000000", out); end
    applied++; if (out_b !== 6'd1) begin miscompares++; $display("FAIL red_xor_prio_b: got %b want 000001", out_b); end
    idle();
    tick();
    applied++; if (out !== 6'd1) begin miscompares++; $display("FAIL red_xor_b: got %b want 000001", out); end
  endtask

  task automatic test_bypass();
    drive(OP_MUL, 3'b110, 3'b001);
    bypass_A = 1'b1;
    bypass_B = 1'b1;
    tick();
    drive(OP_ADD, 3'b011, 3'b101);
    bypass_B = 1'b1;
    tick();
    applied++; if (out !== 6'b111110) begin miscompares++; $display("FAIL byp_prio_a: got %b want 111110", out); end
    applied++; if (out_b !== 6'b000001) begin miscompares++; $display("FAIL byp_prio_b: got %b want 000001", out_b); end
    drive(OP_INV6, 3'b011, 3'b011);
    bypass_A = 1'b1;
    tick();
    applied++; if (out !== 6'b111101) begin miscompares++; $display("FAIL byp_b_only: got %b want 111101", out); end
    drive(OP_XOR, 3'b101, 3'b011);
    tick();
    applied++; if (out !== 6'd0) begin miscompares++; $display("FAIL ill_over_byp: got %b want 000000", out); end
    idle();
    tick();
    applied++; if (out !== 6'b111110) begin miscompares++; $display("FAIL xor_sext: got %b want 111110", out); end
  endtask

  initial begin
    applied     = 0;
    miscompares = 0;
    rst         = 1'b1;
    drive(OP_AND, 3'd0, 3'd0);
    idle();
    test_reset();
    test_mul();
    test_add();
    test_shift_rotate();
    test_illegal();
    test_reduction();
    test_bypass();
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
